// File: rtl/sw_debounce_ctrl.sv
// Debounce sequencer: samples the synchronized switch vector on a prescaled tick and
// publishes it once stable; SW_DEBOUNCE_IRQ_MASK_EN adds a per-bit interrupt mask.
module sw_debounce_ctrl #(
   parameter int WIDTH      = 32,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_sw,
   input  logic             i_enable,
   input  logic             i_clr_we,
   input  logic [WIDTH-1:0] i_clr_mask,
`ifdef SW_DEBOUNCE_IRQ_MASK_EN
   input  logic [WIDTH-1:0] i_irq_mask,
`endif
   output logic [WIDTH-1:0] o_sw_stable,
   output logic [WIDTH-1:0] o_change,
   output logic             o_irq,
   output logic             o_tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = 4;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CNT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_EVAL   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] change_q, change_d;
   logic             tick;

   assign tick = (state_q != S_IDLE) && (presc_q == PRESC_MAX);

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
      stable_d = stable_q;
      change_d = change_q;

      if (i_clr_we) begin
         change_d = change_q & ~i_clr_mask;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (i_enable) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tick) begin
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            if ((cnt_q == '0) || (i_sw != cand_q)) begin
               cand_d = i_sw;
               cnt_d  = CW'(1);
            end else if (cnt_q < CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            // A saturated count on the already-published value must not re-commit.
            if ((cnt_d == CNT_MAX) && (cand_d != stable_q)) begin
               state_d = S_COMMIT;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_COMMIT: begin
            stable_d = cand_q;
            change_d = change_d | (cand_q ^ stable_q);
            state_d  = S_WAIT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_q == S_IDLE) begin
         presc_d = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      if (!i_enable) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         cnt_q    <= '0;
         cand_q   <= '0;
         stable_q <= '0;
         change_q <= '0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         cand_q   <= cand_d;
         stable_q <= stable_d;
         change_q <= change_d;
      end
   end

   assign o_sw_stable = stable_q;
   assign o_change    = change_q;
   assign o_tick      = tick;
`ifdef SW_DEBOUNCE_IRQ_MASK_EN
   assign o_irq = |(change_q & i_irq_mask);
`else
   assign o_irq = |change_q;
`endif

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Bench for sw_debounce_ctrl (TICK_DIV=4, STABLE_CNT=3): vector table, corner sequences,
// and random stimulus against a sample-history reference model.
module tb_sw_debounce_ctrl;

   localparam int W  = 32;
   localparam int TD = 4;
   localparam int SC = 3;

   logic         clk;
   logic         i_reset;
   logic [W-1:0] i_sw;
   logic         i_enable;
   logic         i_clr_we;
   logic [W-1:0] i_clr_mask;
   logic [W-1:0] o_sw_stable;
   logic [W-1:0] o_change;
   logic         o_irq;
   logic         o_tick;

   sw_debounce_ctrl #(
      .WIDTH     (W),
      .TICK_DIV  (TD),
      .STABLE_CNT(SC)
   ) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_sw       (i_sw),
      .i_enable   (i_enable),
      .i_clr_we   (i_clr_we),
      .i_clr_mask (i_clr_mask),
`ifdef SW_DEBOUNCE_IRQ_MASK_EN
      .i_irq_mask ({W{1'b1}}),
`endif
      .o_sw_stable(o_sw_stable),
      .o_change   (o_change),
      .o_irq      (o_irq),
      .o_tick     (o_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: run flag + cycles since enable, and the history of evaluated samples.
   bit           m_run;
   int           m_cnt;
   int           m_nevals;
   logic [W-1:0] m_hist[$];
   logic [W-1:0] m_stable, m_change, m_pval;
   bit           m_pend;

   typedef struct {
      int           n;
      logic         en;
      logic [W-1:0] sw;
      logic         clr_we;
      logic [W-1:0] mask;
      logic [W-1:0] e_stable;
      logic [W-1:0] e_change;
      logic         e_irq;
      logic         e_tick;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run    = 1'b0;
      m_cnt    = 0;
      m_hist.delete();
      m_stable = '0;
      m_change = '0;
      m_pval   = '0;
      m_pend   = 1'b0;
   endtask

   task automatic check_all();
      bit e_tick;
      e_tick = m_run && ((m_cnt % TD) == TD - 1);
      chk("model_stable", o_sw_stable, m_stable);
      chk("model_change", o_change, m_change);
      chk("model_irq", 32'(o_irq), 32'(|m_change));
      chk("model_tick", 32'(o_tick), 32'(e_tick));
   endtask

   task automatic step();
      logic [W-1:0] clr, n_stable, n_change, n_pval;
      bit           n_pend, is_eval, same;
      clr      = i_clr_we ? i_clr_mask : '0;
      n_stable = m_stable;
      n_change = m_change & ~clr;
      n_pend   = 1'b0;
      n_pval   = m_pval;
      if (m_pend) begin
         n_stable = m_pval;
         n_change = n_change | (m_pval ^ m_stable);
      end
      is_eval = m_run && (m_cnt >= TD) && ((m_cnt % TD) == 0);
      if (!i_enable) begin
         m_run = 1'b0;
         m_hist.delete();
      end else if (!m_run) begin
         m_run = 1'b1;
         m_cnt = 0;
      end else begin
         if (is_eval) begin
            m_nevals++;
            m_hist.push_back(i_sw);
            if (m_hist.size() > SC) void'(m_hist.pop_front());
            same = (m_hist.size() == SC);
            foreach (m_hist[k]) if (m_hist[k] != i_sw) same = 1'b0;
            if (same && (i_sw != m_stable)) begin
               n_pend = 1'b1;
               n_pval = i_sw;
            end
         end
         m_cnt++;
      end
      @(posedge clk);
      m_stable = n_stable;
      m_change = n_change;
      m_pend   = n_pend;
      m_pval   = n_pval;
      #1;
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      int cycles;
      int base;
      int r;

      tbl[0] = '{1,  1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0, 1'b0};
      tbl[1] = '{12, 1'b1, 32'hA5, 1'b0, 32'h0,  32'h0,  32'h0,  1'b0, 1'b1};
      tbl[2] = '{2,  1'b1, 32'hA5, 1'b0, 32'h0,  32'h0,  32'h0,  1'b0, 1'b0};
      tbl[3] = '{1,  1'b1, 32'hA5, 1'b0, 32'h0,  32'hA5, 32'hA5, 1'b1, 1'b0};
      tbl[4] = '{20, 1'b1, 32'hA5, 1'b0, 32'h0,  32'hA5, 32'hA5, 1'b1, 1'b0};
      tbl[5] = '{1,  1'b1, 32'hA5, 1'b1, 32'h05, 32'hA5, 32'hA0, 1'b1, 1'b1};
      tbl[6] = '{1,  1'b1, 32'hA5, 1'b0, 32'h0,  32'hA5, 32'hA0, 1'b1, 1'b0};
      tbl[7] = '{1,  1'b1, 32'hA5, 1'b1, 32'hA0, 32'hA5, 32'h00, 1'b0, 1'b0};

      i_reset    = 1'b1;
      i_sw       = '0;
      i_enable   = 1'b0;
      i_clr_we   = 1'b0;
      i_clr_mask = '0;
      m_nevals   = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stable", o_sw_stable, 32'h0);
      chk("reset_change", o_change, 32'h0);
      chk("reset_irq", 32'(o_irq), 32'h0);
      chk("reset_tick", 32'(o_tick), 32'h0);
      i_reset = 1'b0;

      // Clean change and clear via the vector table.
      for (int v = 0; v < 8; v++) begin
         i_enable   = tbl[v].en;
         i_sw       = tbl[v].sw;
         i_clr_we   = tbl[v].clr_we;
         i_clr_mask = tbl[v].mask;
         repeat (tbl[v].n) step();
         chk($sformatf("tbl%0d_stable", v), o_sw_stable, tbl[v].e_stable);
         chk($sformatf("tbl%0d_change", v), o_change, tbl[v].e_change);
         chk($sformatf("tbl%0d_irq", v), 32'(o_irq), 32'(tbl[v].e_irq));
         chk($sformatf("tbl%0d_tick", v), 32'(o_tick), 32'(tbl[v].e_tick));
      end
      i_clr_we   = 1'b0;
      i_clr_mask = '0;

      // Asynchronous reset mid-count with all low flags set.
      i_sw  = 32'h5A;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (m_change == 32'hFF) begin
            found = 1;
            break;
         end
      end
      chk("ff_commit_seen", found, 1);
      chk("ff_change", o_change, 32'hFF);
      i_sw = 32'h0F;
      repeat (6) step();
      #2;
      i_reset  = 1'b1;
      i_enable = 1'b0;
      #1;
      chk("async_rst_stable", o_sw_stable, 32'h0);
      chk("async_rst_change", o_change, 32'h0);
      chk("async_rst_irq", 32'(o_irq), 32'h0);
      chk("async_rst_tick", 32'(o_tick), 32'h0);
      model_reset();
      @(posedge clk);
      #2;
      i_reset = 1'b0;
      step();

      // Bounce: bit0 alternates across five tick periods, then settles high.
      i_enable = 1'b1;
      for (int b = 0; b < 5; b++) begin
         i_sw = (b % 2 == 0) ? 32'h1 : 32'h0;
         repeat (TD) step();
         chk($sformatf("bounce%0d_no_commit", b), o_sw_stable, 32'h0);
      end
      i_sw = 32'h1;
      repeat (16) step();
      chk("bounce_stable", o_sw_stable, 32'h1);
      chk("bounce_change", o_change, 32'h1);

      // Clear of bit7 lands in the same cycle as the commit that sets it.
      i_sw  = 32'h81;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         if (m_pend) begin
            i_clr_we   = 1'b1;
            i_clr_mask = 32'h80;
            step();
            i_clr_we   = 1'b0;
            i_clr_mask = '0;
            found = 1;
            break;
         end
         step();
      end
      chk("collide_seen", found, 1);
      chk("collide_change", o_change, 32'h81);
      chk("collide_stable", o_sw_stable, 32'h81);

      // Disable after two matching samples; re-enable needs three fresh ones.
      i_sw  = 32'h3C;
      base  = m_nevals;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (m_nevals == base + 2) begin
            found = 1;
            break;
         end
      end
      chk("dis_two_evals", found, 1);
      chk("dis_not_committed", o_sw_stable, 32'h81);
      i_enable = 1'b0;
      step();
      i_enable = 1'b1;
      cycles   = 0;
      found    = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         cycles++;
         if (o_sw_stable == 32'h3C) begin
            found = 1;
            break;
         end
      end
      chk("reen_commit_seen", found, 1);
      chk("reen_latency", cycles, 15);
      chk("reen_change", o_change, 32'hBD);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         i_enable = ($urandom_range(0, 99) != 0);
         r = $urandom_range(0, 29);
         if (r == 0) i_sw = $urandom();
         else if (r == 1) i_sw = i_sw ^ (32'h1 << $urandom_range(0, 31));
         i_clr_we   = ($urandom_range(0, 15) == 0);
         i_clr_mask = $urandom();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
